// File: rtl/lsu_dc_parity_scrub_ctl.sv
// ---------------------------------------------------------------------------
// lsu_dc_parity_scrub_ctl
//   Background dcache parity scrubber. It walks every line index in turn and
//   reads each line through the shared dcache read port, using the port only
//   in cycles the LSU leaves idle. The line's parity is recomputed by an
//   internal parity generator and compared with the stored parity bits. Each
//   mismatching line yields one pulsed error record and bumps a saturating
//   error count.
//
//   Optional feature macro: LSU_DC_SCRUB_ERR_INJECT_EN
//     When defined, this adds input scrub_inj. A pulse on scrub_inj arms a
//     sticky flag. The next CHECK inverts stored parity bit 0 and then clears
//     the flag.
//
// Ports
//   rclk, reset          clock, synchronous active-high reset
//   scrub_en             enable background scrubbing
//   scrub_interval       idle cycles between line reads (0 treated as 1)
//   dc_port_busy         LSU owns the read port this cycle
//   scrub_rd_req/idx     read request and line index
//   scrub_rd_gnt         grant, qualified by scrub_rd_req
//   dc_rd_vld/data/par   returned line data and stored parity
//   scrub_err            1-cycle pulse on a parity mismatch
//   scrub_err_idx/mask   failing line index and parity mask (held)
//   scrub_err_cnt        saturating mismatch-line count
//   scrub_pass_done      1-cycle pulse after the last index is checked
//   dbg_state            current FSM state (debug)
//   scrub_inj            (macro only) arm a parity-bit-0 inversion
// ---------------------------------------------------------------------------

// Per-group XOR parity generator. It is shared in form with the dcache write
// path.
module lsu_dc_par_gen #(
  parameter int WIDTH = 8,
  parameter int NUM   = 16
) (
  input  logic [WIDTH*NUM-1:0] i_data,
  output logic [NUM-1:0]       o_par
);
  always_comb begin
    o_par = '0;
    for (int g = 0; g < NUM; g++) begin
      o_par[g] = ^i_data[g*WIDTH +: WIDTH];
    end
  end
endmodule

module lsu_dc_parity_scrub_ctl #(
  parameter int WIDTH = 8,
  parameter int NUM   = 16,
  parameter int IDX_W = 7,
  parameter int CNT_W = 8
) (
  input  logic                 rclk,
  input  logic                 reset,
  input  logic                 scrub_en,
  input  logic [15:0]          scrub_interval,
  input  logic                 dc_port_busy,
  output logic                 scrub_rd_req,
  output logic [IDX_W-1:0]     scrub_rd_idx,
  input  logic                 scrub_rd_gnt,
  input  logic                 dc_rd_vld,
  input  logic [WIDTH*NUM-1:0] dc_rd_data,
  input  logic [NUM-1:0]       dc_rd_par,
  output logic                 scrub_err,
  output logic [IDX_W-1:0]     scrub_err_idx,
  output logic [NUM-1:0]       scrub_err_mask,
  output logic [CNT_W-1:0]     scrub_err_cnt,
  output logic                 scrub_pass_done,
`ifdef LSU_DC_SCRUB_ERR_INJECT_EN
  input  logic                 scrub_inj,
`endif
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CHECK} state_t;

  localparam logic [IDX_W-1:0] IDX_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t                 r_state;
  logic [15:0]            r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [WIDTH*NUM-1:0]   r_data;
  logic [NUM-1:0]         r_par;
  logic                   r_err;
  logic [IDX_W-1:0]       r_err_idx;
  logic [NUM-1:0]         r_err_mask;
  logic [CNT_W-1:0]       r_err_cnt;
  logic                   r_pass;

  logic [15:0]            w_interval;
  logic [15:0]            w_cnt_inc;
  logic                   w_req;
  logic [NUM-1:0]         w_par_gen;
  logic [NUM-1:0]         w_inj_vec;
  logic [NUM-1:0]         w_mask;

`ifdef LSU_DC_SCRUB_ERR_INJECT_EN
  logic                   r_inj;
`endif

  assign w_interval = (scrub_interval == 16'd0) ? 16'd1 : scrub_interval;
  assign w_cnt_inc  = r_cnt + 16'd1;

  // Read handshake: a transfer happens in a cycle where scrub_rd_req and
  // scrub_rd_gnt are both 1. The request is offered only while the LSU leaves
  // the port idle, so it follows dc_port_busy within the same cycle. A grant
  // with no request is ignored. Once the request is granted, data comes back
  // on dc_rd_vld some later cycle; it is taken only in WAIT.
  assign w_req = (r_state == S_REQ) && scrub_en && !dc_port_busy;

  lsu_dc_par_gen #(.WIDTH(WIDTH), .NUM(NUM)) u_par_gen (
    .i_data (r_data),
    .o_par  (w_par_gen)
  );

  always_comb begin
    w_inj_vec = '0;
`ifdef LSU_DC_SCRUB_ERR_INJECT_EN
    w_inj_vec[0] = r_inj;
`endif
  end

  assign w_mask = w_par_gen ^ (r_par ^ w_inj_vec);

  always_ff @(posedge rclk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_par      <= '0;
      r_err      <= 1'b0;
      r_err_idx  <= '0;
      r_err_mask <= '0;
      r_err_cnt  <= '0;
      r_pass     <= 1'b0;
`ifdef LSU_DC_SCRUB_ERR_INJECT_EN
      r_inj      <= 1'b0;
`endif
    end else begin
      r_err  <= 1'b0;
      r_pass <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!scrub_en) begin
            r_cnt <= '0;
          end else if (w_cnt_inc >= w_interval) begin
            r_cnt   <= '0;
            r_state <= S_REQ;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_REQ: begin
          // Dropping enable before the grant gives up this slot. The index is
          // kept, so the same line is retried later.
          if (!scrub_en) begin
            r_state <= S_IDLE;
          end else if (w_req && scrub_rd_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A granted read always completes, whatever scrub_en does.
          if (dc_rd_vld) begin
            r_data  <= dc_rd_data;
            r_par   <= dc_rd_par;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_mask != '0) begin
            r_err      <= 1'b1;
            r_err_idx  <= r_idx;
            r_err_mask <= w_mask;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_ONE;
          end
          r_pass  <= (r_idx == '1);
          r_idx   <= r_idx + IDX_ONE;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef LSU_DC_SCRUB_ERR_INJECT_EN
      // CHECK consumes the flag. A pulse during CHECK re-arms it for the
      // next line.
      if (r_state == S_CHECK) r_inj <= scrub_inj;
      else if (scrub_inj)     r_inj <= 1'b1;
`endif
    end
  end

  assign scrub_rd_req    = w_req;
  assign scrub_rd_idx    = r_idx;
  assign scrub_err       = r_err;
  assign scrub_err_idx   = r_err_idx;
  assign scrub_err_mask  = r_err_mask;
  assign scrub_err_cnt   = r_err_cnt;
  assign scrub_pass_done = r_pass;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_lsu_dc_parity_scrub_ctl.sv
// Testbench for lsu_dc_parity_scrub_ctl. The bench plays the dcache read port.
// Each returned line pushes its expected record {err, pass_done, err_idx,
// err_mask, err_cnt} onto exp_q. The record is popped and compared two cycles
// later.
module tb_lsu_dc_parity_scrub_ctl;
  localparam int WIDTH = 8;
  localparam int NUM   = 16;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;
  localparam int DW    = WIDTH*NUM;
  localparam int REC_W = 2 + IDX_W + NUM + CNT_W;

  logic              rclk;
  logic              reset;
  logic              scrub_en;
  logic [15:0]       scrub_interval;
  logic              dc_port_busy;
  logic              scrub_rd_req;
  logic [IDX_W-1:0]  scrub_rd_idx;
  logic              scrub_rd_gnt;
  logic              dc_rd_vld;
  logic [DW-1:0]     dc_rd_data;
  logic [NUM-1:0]    dc_rd_par;
  logic              scrub_err;
  logic [IDX_W-1:0]  scrub_err_idx;
  logic [NUM-1:0]    scrub_err_mask;
  logic [CNT_W-1:0]  scrub_err_cnt;
  logic              scrub_pass_done;
  logic              scrub_inj;
  logic [1:0]        dbg_state;

  logic [REC_W-1:0]  exp_q[$];
  int                n_pass;
  int                n_total;

  // reference model state
  logic [IDX_W-1:0]  m_idx;
  logic [IDX_W-1:0]  m_err_idx;
  logic [NUM-1:0]    m_err_mask;
  logic [CNT_W-1:0]  m_cnt;
  logic              m_inj;

  lsu_dc_parity_scrub_ctl #(.WIDTH(WIDTH), .NUM(NUM), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .rclk            (rclk),
    .reset           (reset),
    .scrub_en        (scrub_en),
    .scrub_interval  (scrub_interval),
    .dc_port_busy    (dc_port_busy),
    .scrub_rd_req    (scrub_rd_req),
    .scrub_rd_idx    (scrub_rd_idx),
    .scrub_rd_gnt    (scrub_rd_gnt),
    .dc_rd_vld       (dc_rd_vld),
    .dc_rd_data      (dc_rd_data),
    .dc_rd_par       (dc_rd_par),
    .scrub_err       (scrub_err),
    .scrub_err_idx   (scrub_err_idx),
    .scrub_err_mask  (scrub_err_mask),
    .scrub_err_cnt   (scrub_err_cnt),
    .scrub_pass_done (scrub_pass_done),
`ifdef LSU_DC_SCRUB_ERR_INJECT_EN
    .scrub_inj       (scrub_inj),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [NUM-1:0] gen_par(input logic [DW-1:0] d);
    logic [NUM-1:0] p;
    p = '0;
    for (int g = 0; g < NUM; g++)
      for (int b = 0; b < WIDTH; b++) p[g] = p[g] ^ d[g*WIDTH + b];
    return p;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_idx = '0; m_err_idx = '0; m_err_mask = '0; m_cnt = '0; m_inj = 1'b0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1; scrub_en = 1'b0; dc_port_busy = 1'b0;
    scrub_rd_gnt = 1'b0; dc_rd_vld = 1'b0; scrub_inj = 1'b0;
    repeat (2) @(negedge rclk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge rclk); #1;
      if (scrub_rd_req === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL req_timeout: scrub_rd_req=%b after 300 cycles, required 1", scrub_rd_req);
    end
  endtask

  // Called with scrub_rd_req already high: grant, return the line, check record.
  task automatic serve_line(input logic [DW-1:0] d, input logic [NUM-1:0] p, input int lat);
    logic [NUM-1:0]   m;
    logic             e;
    logic             pd;
    logic [REC_W-1:0] exp_rec;
    logic [REC_W-1:0] act;
    n_total++;
    if (scrub_rd_idx !== m_idx)
      $display("FAIL rd_idx: got %0d required %0d", scrub_rd_idx, m_idx);
    else n_pass++;
    scrub_rd_gnt = 1'b1;
    @(negedge rclk);
    scrub_rd_gnt = 1'b0;
    repeat (lat) @(negedge rclk);
    m  = gen_par(d) ^ p ^ {{(NUM-1){1'b0}}, m_inj};
    m_inj = 1'b0;
    e  = (m != '0);
    pd = (m_idx == '1);
    if (e) begin
      m_err_idx  = m_idx;
      m_err_mask = m;
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
    m_idx = m_idx + 1'b1;
    exp_q.push_back({e, pd, m_err_idx, m_err_mask, m_cnt});
    dc_rd_vld = 1'b1; dc_rd_data = d; dc_rd_par = p;
    @(negedge rclk);
    dc_rd_vld = 1'b0; dc_rd_data = rand_data(); dc_rd_par = 16'(($urandom));
    @(negedge rclk); #1;
    act = {scrub_err, scrub_pass_done, scrub_err_idx, scrub_err_mask, scrub_err_cnt};
    exp_rec = exp_q.pop_front();
    n_total++;
    if (act !== exp_rec)
      $display("FAIL line_record: got {err,pass,idx,mask,cnt}=%h required %h", act, exp_rec);
    else n_pass++;
  endtask

  task automatic do_line(input logic [DW-1:0] d, input logic [NUM-1:0] p);
    bit ok;
    wait_req(ok);
    if (ok) serve_line(d, p, $urandom_range(0, 2));
  endtask

  task automatic clean_line();
    logic [DW-1:0] d;
    d = rand_data();
    do_line(d, gen_par(d));
  endtask

  task automatic bad_line();
    logic [DW-1:0] d;
    logic [NUM-1:0] f;
    d = rand_data();
    f = 16'($urandom_range(1, 65535));
    do_line(d, gen_par(d) ^ f);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    n_total++;
    if ({scrub_rd_req, scrub_rd_idx, scrub_err, scrub_err_idx, scrub_err_mask,
         scrub_err_cnt, scrub_pass_done, dbg_state} !== '0)
      $display("FAIL reset_outputs: req=%b idx=%0d err=%b eidx=%0d mask=%h cnt=%0d pass=%b st=%0d required all 0",
               scrub_rd_req, scrub_rd_idx, scrub_err, scrub_err_idx, scrub_err_mask,
               scrub_err_cnt, scrub_pass_done, dbg_state);
    else n_pass++;
  endtask

  task automatic test_basic();
    int first;
    logic [DW-1:0] d;
    first = -1;
    @(negedge rclk);
    scrub_en = 1'b1; scrub_interval = 16'd4;
    for (int c = 1; c <= 20; c++) begin
      @(negedge rclk); #1;
      if (scrub_rd_req === 1'b1) begin first = c; break; end
    end
    n_total++;
    if (first != 4) $display("FAIL first_req_cycle: got %0d required 4", first);
    else n_pass++;
    if (first > 0) begin
      d = rand_data();
      serve_line(d, gen_par(d), 1);
    end
    clean_line();
    clean_line();
  endtask

  task automatic test_err();
    scrub_interval = 16'd2;
    while (m_idx != 3'd5) clean_line();
    do_line('0, 16'h0001);
    @(negedge rclk); #1;
    n_total++;
    if (scrub_err !== 1'b0 || scrub_err_idx !== 3'd5 || scrub_err_mask !== 16'h0001 || scrub_err_cnt !== 8'd1)
      $display("FAIL err_pulse_hold: err=%b idx=%0d mask=%h cnt=%0d required 0/5/0001/1",
               scrub_err, scrub_err_idx, scrub_err_mask, scrub_err_cnt);
    else n_pass++;
  endtask

  task automatic test_busy();
    bit in_req;
    logic [DW-1:0] d;
    in_req = 1'b0;
    dc_port_busy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge rclk); #1;
      if (dbg_state == 2'd1) begin in_req = 1'b1; break; end
    end
    n_total++;
    if (!in_req) $display("FAIL busy_reach_req: state=%0d required 1", dbg_state);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (scrub_rd_req !== 1'b0 || scrub_rd_idx !== m_idx)
        $display("FAIL busy_hold: req=%b idx=%0d required 0/%0d", scrub_rd_req, scrub_rd_idx, m_idx);
      else n_pass++;
      @(negedge rclk); #1;
    end
    dc_port_busy = 1'b0;
    #1;
    n_total++;
    if (scrub_rd_req !== 1'b1) $display("FAIL busy_release: req=%b required 1", scrub_rd_req);
    else begin
      n_pass++;
      d = rand_data();
      serve_line(d, gen_par(d), 0);
    end
  endtask

  task automatic test_pass();
    for (int i = 0; i < 9; i++) begin
      if ($urandom_range(0, 1) == 0) clean_line();
      else bad_line();
    end
  endtask

  task automatic test_saturate();
    scrub_interval = 16'd0;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) bad_line();
    n_total++;
    if (scrub_err_cnt !== 8'hFF) $display("FAIL err_cnt_sat: got %h required ff", scrub_err_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    scrub_interval = 16'd1;
    wait_req(ok);
    if (ok) begin
      scrub_rd_gnt = 1'b1;
      @(negedge rclk);
      scrub_rd_gnt = 1'b0;
      scrub_en = 1'b0;
      reset = 1'b1;
      @(negedge rclk);
      reset = 1'b0;
      model_reset();
      dc_rd_vld = 1'b1; dc_rd_data = '0; dc_rd_par = 16'h0001; scrub_rd_gnt = 1'b1;
      @(negedge rclk);
      dc_rd_vld = 1'b0; scrub_rd_gnt = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge rclk); #1;
        n_total++;
        if ({scrub_rd_req, scrub_rd_idx, scrub_err, scrub_err_idx, scrub_err_mask,
             scrub_err_cnt, scrub_pass_done} !== '0)
          $display("FAIL reset_in_wait: req=%b idx=%0d err=%b eidx=%0d mask=%h cnt=%0d pass=%b required all 0",
                   scrub_rd_req, scrub_rd_idx, scrub_err, scrub_err_idx, scrub_err_mask,
                   scrub_err_cnt, scrub_pass_done);
        else n_pass++;
      end
    end
  endtask

`ifdef LSU_DC_SCRUB_ERR_INJECT_EN
  task automatic test_inject();
    @(negedge rclk);
    scrub_en = 1'b1; scrub_interval = 16'd3;
    scrub_inj = 1'b1;
    @(negedge rclk);
    scrub_inj = 1'b0;
    m_inj = 1'b1;
    clean_line();
    n_total++;
    if (scrub_err_mask !== 16'h0001) $display("FAIL inject_mask: got %h required 0001", scrub_err_mask);
    else n_pass++;
    clean_line();
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; scrub_en = 1'b0; scrub_interval = 16'd4; dc_port_busy = 1'b0;
    scrub_rd_gnt = 1'b0; dc_rd_vld = 1'b0; dc_rd_data = '0; dc_rd_par = '0; scrub_inj = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_err();
    test_busy();
    test_pass();
    test_saturate();
    test_reset_in_wait();
`ifdef LSU_DC_SCRUB_ERR_INJECT_EN
    test_inject();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
